riscv_lsu: RTL and testbench
============================

# riscv_lsu

Parametrised load/store unit between a multicycle RISC-V core and the single-port system bus (`a`/`d`/`we`/`rd`/`spo`/`ready`). It accepts one load or store request at a time and handles byte, half, word and (XLEN=64) double sizes. Sub-word stores are done by read-modify-write, because the bus has no byte enables. Misaligned addresses are detected and reported as RISC-V exception causes, and the unit returns a single-cycle response to the core.

## Interface
Parameters:
- `XLEN`, 32, data and bus width; 32 or 64.
- `ADDR_W`, 32, address width.
- `TIMEOUT`, 255, maximum bus wait cycles before an access fault; used only with `LSU_TIMEOUT_EN`.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk` in 1 — clock, rising edge.
- `rst_n` in 1 — asynchronous active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — unit idle; request accepted when `req_valid & req_ready`.
- `req_we` in 1 — 1 selects store, 0 selects load.
- `req_size` in 2 — 0 byte, 1 half, 2 word, 3 double.
- `req_unsigned` in 1 — load zero-extends instead of sign-extending.
- `req_addr` in ADDR_W — byte address.
- `req_wdata` in XLEN — store data, right-aligned.
- `rsp_valid` out 1 — one-cycle response pulse.
- `rsp_rdata` out XLEN — load result, extended.
- `rsp_err` out 1 — request faulted.
- `rsp_cause` out 4 — mcause code, valid when `rsp_err` is high.
- `a` out ADDR_W — bus word address.
- `d` out XLEN — bus write data.
- `we` out 1 — bus write strobe.
- `rd` out 1 — bus read strobe.
- `spo` in XLEN — bus read data.
- `ready` in 1 — bus access complete.

## Operation
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- **IDLE:** `req_ready`=1. On accept, request fields are latched and the transition is chosen as follows:
  - Misaligned, i.e. `addr` mod 2^size ≠ 0 → RESP, `rsp_err`=1, cause 4 (load) or 6 (store).
  - `req_size`=3 with XLEN=32 → RESP, cause 2.
  - Otherwise: load → RD; full-width store → WR; sub-word store → RMW_RD.
  - No bus activity on any error path.
- **Bus addressing:** `a` = `req_addr` with the low log2(XLEN/8) bits cleared.
- **Byte-lane swap:** bus lanes are byte-swapped. Little-endian byte k of the word maps to `spo`/`d` bits [XLEN-1-8k : XLEN-8-8k].
- **RD / RMW_RD:** `rd`=1 and `a` are held until `ready` is sampled high. On that cycle the un-swapped word is captured.
  - RD → RESP: the addressed lane is extracted and sign- or zero-extended to XLEN.
  - RMW_RD → RMW_WR: the store bytes are merged into the captured word.
- **WR / RMW_WR:** `we`=1, `a` and `d` are held until `ready` is high, then → RESP.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then → IDLE. The core always accepts responses; there is no response backpressure.
- **Output registering:** all bus outputs and response outputs are registered.
- **Idle outputs:** `rd`/`we` are 0 outside the bus states. `a`/`d` keep their last values.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_cause`=0, `a`=0, `d`=0, `we`=0, `rd`=0; state IDLE.
- Zero-wait bus (`ready` high on the first strobe cycle); cycle 0 is the accept cycle:
  - Load / full-width store: strobe in cycle 1, `rsp_valid` in cycle 2.
  - Sub-word store: `rd` in cycle 1, `we` in cycle 2, `rsp_valid` in cycle 3.
  - Each bus cycle with `ready` low adds one cycle.
- Error path: `rsp_valid` in cycle 1.
- `req_ready` is 0 from the cycle after accept through the RESP cycle. It returns to 1 the cycle after RESP, so the next accept can happen no earlier than that cycle.
- `ready` is ignored outside RD/WR/RMW_RD/RMW_WR.
- `rst_n` low mid-access: `rd`/`we` drop immediately (asynchronous), no response is issued, state returns to IDLE.

## Configuration
- Macro: `LSU_TIMEOUT_EN`.
- Defined: a wait counter clears on entry to each bus state and increments while `ready` is low. When it reaches `TIMEOUT`:
  - `rd`/`we` drop and the state goes to RESP with `rsp_err`=1.
  - Cause 5 for a load; cause 7 for a store, including a timeout during RMW_RD.
- Undefined: no counter; the unit waits for `ready` indefinitely.

## Test plan
All scenarios use XLEN=32 and memory word 0x100 = 0x8899AABB (little-endian).
- LW 0x100, zero-wait bus → `rd` in cycle 1, `a`=0x100, `spo`=0xBBAA9988; `rsp_rdata`=0x8899AABB in cycle 2.
- LB 0x103 → `rsp_rdata`=0xFFFFFF88. LBU 0x103 → 0x00000088. LHU 0x102 → 0x00008899.
- SB 0x5A to 0x101 → `rd` in cycle 1, `we` in cycle 2 with `d`=0xBB5A9988; memory becomes 0x88995ABB; `rsp_valid` in cycle 3.
- LH 0x101 → `rsp_err`=1, `rsp_cause`=4 in cycle 1; `rd`/`we` stay 0. SW 0x102 → `rsp_cause`=6.
- With `LSU_TIMEOUT_EN`, `TIMEOUT`=4, `ready` tied low on LW → `rd` high for 4 cycles, then `rsp_err`=1, `rsp_cause`=5. SB under the same stall → `rsp_cause`=7.
- Assert `rst_n` low during the `ready`-low wait of an SW → `we` is 0 immediately, no `rsp_valid`, `req_ready`=1 after release.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-request load/store unit between a multicycle RISC-V core and a byte-swapped,
// single-port system bus. Defining LSU_TIMEOUT_EN adds a bus-wait timeout that reports an access fault.
module riscv_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [3:0]        rsp_cause,
  output logic [ADDR_W-1:0] a,
  output logic [XLEN-1:0]   d,
  output logic              we,
  output logic              rd,
  input  logic [XLEN-1:0]   spo,
  input  logic              ready
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
  state_t state;

  logic            lat_we;
  logic            lat_unsigned;
  logic [1:0]      lat_size;
  logic [OFFW-1:0] lat_off;
  logic [XLEN-1:0] lat_wdata;

  logic              misaligned;
  logic              size_bad;
  logic              full_store;
  logic              stall_fault;
  logic [ADDR_W-1:0] word_addr;

  // Bus lanes carry little-endian byte k at the opposite end of the word.
  function automatic logic [XLEN-1:0] swap(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      r[XLEN-1-8*k -: 8] = x[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
    logic [XLEN-1:0] m;
    m = '1;
    if (size < 2'(OFFW)) begin
      m = (XLEN'(1) << (8 << size)) - XLEN'(1);
    end
    return m;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [OFFW-1:0] off,
                                                  input logic [1:0]      size,
                                                  input logic            uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] m;
    logic            sign;
    sh   = word >> {off, 3'b000};
    m    = size_mask(size);
    sign = |(sh & m & ~(m >> 1));
    return (uns || !sign) ? (sh & m) : ((sh & m) | ~m);
  endfunction

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] word,
                                            input logic [XLEN-1:0] wdata,
                                            input logic [OFFW-1:0] off,
                                            input logic [1:0]      size);
    logic [XLEN-1:0] m;
    m = size_mask(size);
    return (word & ~(m << {off, 3'b000})) | ((wdata & m) << {off, 3'b000});
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign size_bad   = 32'(req_size) > OFFW;
  assign full_store = 32'(req_size) == OFFW;
  assign word_addr  = req_addr & ~ADDR_W'(NB - 1);

`ifdef LSU_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        in_bus;

  assign in_bus = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);

  // Any cycle with ready high or outside a bus state restarts the count, so each bus state starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (in_bus && !ready) begin
      wait_cnt <= wait_cnt + 32'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign stall_fault = in_bus && !ready && ((wait_cnt + 32'd1) >= 32'(TIMEOUT));
`else
  assign stall_fault = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_cause    <= '0;
      a            <= '0;
      d            <= '0;
      we           <= 1'b0;
      rd           <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= '0;
      lat_off      <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_off      <= req_addr[OFFW-1:0];
            lat_wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (misaligned) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_cause <= req_we ? 4'd6 : 4'd4;
            end else if (size_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_cause <= 4'd2;
            end else begin
              a <= word_addr;
              if (!req_we) begin
                state <= RD;
                rd    <= 1'b1;
              end else if (full_store) begin
                state <= WR;
                we    <= 1'b1;
                d     <= swap(req_wdata);
              end else begin
                state <= RMW_RD;
                rd    <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (ready) begin
            rd        <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_cause <= '0;
            rsp_rdata <= load_extend(swap(spo), lat_off, lat_size, lat_unsigned);
          end else if (stall_fault) begin
            rd        <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_cause <= 4'd5;
          end
        end
        RMW_RD: begin
          if (ready) begin
            rd    <= 1'b0;
            we    <= 1'b1;
            d     <= swap(merge(swap(spo), lat_wdata, lat_off, lat_size));
            state <= RMW_WR;
          end else if (stall_fault) begin
            rd        <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_cause <= 4'd7;
          end
        end
        WR, RMW_WR: begin
          if (ready) begin
            we        <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_cause <= '0;
          end else if (stall_fault) begin
            we        <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_cause <= 4'd7;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu (XLEN=32): directed vector table, hand sequences for stalls,
// reset mid-access and (with LSU_TIMEOUT_EN) timeouts, then random traffic against a byte-array model.
module tb_riscv_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  rsp_cause;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready = 1'b1;

  riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_cause(rsp_cause),
    .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];

  // Bus memory: little-endian byte k travels on the byte-swapped lane.
  always_comb begin
    spo = '0;
    for (int k = 0; k < 4; k++) spo[31-8*k -: 8] = mem[{a[9:2], 2'(k)}];
  end

  always @(posedge clk) begin
    if (we && ready)
      for (int k = 0; k < 4; k++) mem[{a[9:2], 2'(k)}] <= d[31-8*k -: 8];
  end

  // ready modes: 0 always high, 1 random (at most 2 low in a row), 2 always low, 3 low for stall_left strobe cycles
  int ready_mode = 0;
  int stall_left = 0;
  int low_run = 0;
  always @(negedge clk) begin
    case (ready_mode)
      0: ready = 1'b1;
      1: begin
        ready = (low_run >= 2) || ($urandom_range(0, 2) != 0);
        low_run = ready ? 0 : low_run + 1;
      end
      2: ready = 1'b0;
      default: begin
        ready = (stall_left == 0);
        if ((rd || we) && stall_left > 0) stall_left--;
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain byte array, natural alignment and size rules.
  function automatic void model(input logic rwe, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err, output logic [3:0] cause);
    int unsigned nbytes;
    longint unsigned v;
    nbytes = 1 << sz;
    rdata = '0; err = 1'b0; cause = '0;
    if (addr % nbytes != 0) begin
      err = 1'b1; cause = rwe ? 4'd6 : 4'd4; return;
    end
    if (nbytes > 4) begin
      err = 1'b1; cause = 4'd2; return;
    end
    if (rwe) begin
      for (int i = 0; i < int'(nbytes); i++) ref_mem[int'((addr + i) % 1024)] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < int'(nbytes); i++) v |= longint'(ref_mem[int'((addr + i) % 1024)]) << (8 * i);
      if (!uns && v[8*nbytes-1]) v |= ~((64'd1 << (8 * nbytes)) - 64'd1);
      rdata = 32'(v);
    end
  endfunction

  typedef struct {
    int lat;
    logic [31:0] rdata;
    logic err;
    logic [3:0] cause;
    int rd_first, we_first, rd_cnt, we_cnt;
    logic [31:0] a_seen, d_seen;
  } obs_t;

  task automatic do_req(input logic rwe, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag, output obs_t o);
    int cyc;
    int rr_bad;
    bit got;
    o.lat = -1; o.rdata = '0; o.err = 1'b0; o.cause = '0;
    o.rd_first = -1; o.we_first = -1; o.rd_cnt = 0; o.we_cnt = 0; o.a_seen = '0; o.d_seen = '0;
    @(negedge clk);
    check($sformatf("%s_idle_ready", tag), 32'(req_ready), 1);
    req_valid = 1'b1; req_we = rwe; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    cyc = 0; got = 0; rr_bad = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rd) begin
        o.rd_cnt++;
        if (o.rd_first < 0) begin o.rd_first = cyc; o.a_seen = a; end
      end
      if (we) begin
        o.we_cnt++;
        if (o.we_first < 0) begin o.we_first = cyc; o.d_seen = d; o.a_seen = a; end
      end
      if (req_ready) rr_bad++;
      if (rsp_valid) begin
        got = 1; o.lat = cyc; o.rdata = rsp_rdata; o.err = rsp_err; o.cause = rsp_cause;
      end
    end
    check($sformatf("%s_rsp_seen", tag), 32'(got), 1);
    check($sformatf("%s_busy_ready", tag), 32'(rr_bad), 0);
    @(negedge clk);
    check($sformatf("%s_pulse_end", tag), {30'd0, rsp_valid, req_ready}, 32'h1);
  endtask

  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr, wdata, rdata;
    logic err; logic [3:0] cause; int lat, rd_first, we_first; logic [31:0] d;
  } vec_t;

  vec_t tv [18];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    logic [31:0] erd;
    logic ee;
    logic [3:0] ec;
    bit seen;
    int nbad;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[32'h100] = 8'hBB; mem[32'h101] = 8'hAA; mem[32'h102] = 8'h99; mem[32'h103] = 8'h88;
    for (int i = 32'h100; i < 32'h104; i++) ref_mem[i] = mem[i];

    //       we    sz    uns   addr        wdata         rdata         err   cause lat rd  we  d
    tv[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[1]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'hFFFFFF88, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[2]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h00000088, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[3]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h00008899, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[4]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'hFFFF8899, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[5]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFF5A, 32'h0,        1'b0, 4'd0, 3, 1,  2, 32'hBB5A9988};
    tv[6]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h88995ABB, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[7]  = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 4'd4, 1, -1, -1, 32'h0};
    tv[8]  = '{1'b1, 2'd2, 1'b0, 32'h102, 32'h12345678, 32'h0,        1'b1, 4'd6, 1, -1, -1, 32'h0};
    tv[9]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 4'd2, 1, -1, -1, 32'h0};
    tv[10] = '{1'b1, 2'd3, 1'b0, 32'h108, 32'h0,        32'h0,        1'b1, 4'd2, 1, -1, -1, 32'h0};
    tv[11] = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234BEEF, 32'h0,        1'b0, 4'd0, 3, 1,  2, 32'hBB5AEFBE};
    tv[12] = '{1'b1, 2'd2, 1'b0, 32'h104, 32'h11223344, 32'h0,        1'b0, 4'd0, 2, -1, 1, 32'h44332211};
    tv[13] = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        32'h11223344, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[14] = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'hFFFFFFBB, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[15] = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0,        32'h00005ABB, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[16] = '{1'b0, 2'd0, 1'b1, 32'h102, 32'h0,        32'h000000EF, 1'b0, 4'd0, 2, 1, -1, 32'h0};
    tv[17] = '{1'b0, 2'd1, 1'b0, 32'h106, 32'h0,        32'h00001122, 1'b0, 4'd0, 2, 1, -1, 32'h0};

    // Reset values while rst_n is held low
    #12;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp", {26'd0, rsp_valid, rsp_err, rsp_cause}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_a", a, 32'h0);
    check("rst_d", d, 32'h0);
    check("rst_strobes", {30'd0, we, rd}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      model(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, erd, ee, ec);
      do_req(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, $sformatf("v%0d", i), o);
      check($sformatf("v%0d_lat", i), 32'(o.lat), 32'(tv[i].lat));
      check($sformatf("v%0d_err", i), {27'd0, o.err, o.cause}, {27'd0, tv[i].err, tv[i].cause});
      check($sformatf("v%0d_rd_cycle", i), 32'(o.rd_first), 32'(tv[i].rd_first));
      check($sformatf("v%0d_we_cycle", i), 32'(o.we_first), 32'(tv[i].we_first));
      if (!tv[i].we && !tv[i].err) check($sformatf("v%0d_rdata", i), o.rdata, tv[i].rdata);
      if (tv[i].we_first > 0) check($sformatf("v%0d_d", i), o.d_seen, tv[i].d);
      if (!tv[i].err) check($sformatf("v%0d_a", i), o.a_seen, tv[i].addr & 32'hFFFFFFFC);
    end

    // Stalled bus: three ready-low cycles stretch the strobe
    ready_mode = 3; stall_left = 3;
    model(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, erd, ee, ec);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "stall_lw", o);
    check("stall_lw_lat", 32'(o.lat), 5);
    check("stall_lw_rd_cnt", 32'(o.rd_cnt), 4);
    check("stall_lw_rdata", o.rdata, 32'hBEEF5ABB);
    stall_left = 3;
    model(1'b1, 2'd0, 1'b0, 32'h103, 32'h77, erd, ee, ec);
    do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h77, "stall_sb", o);
    check("stall_sb_lat", 32'(o.lat), 6);
    check("stall_sb_d", o.d_seen, 32'hBB5AEF77);

`ifdef LSU_TIMEOUT_EN
    ready_mode = 2;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "to_lw", o);
    check("to_lw_err", {27'd0, o.err, o.cause}, {27'd0, 1'b1, 4'd5});
    check("to_lw_rd_cnt", 32'(o.rd_cnt), 4);
    check("to_lw_lat", 32'(o.lat), 5);
    do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h11, "to_sb", o);
    check("to_sb_err", {27'd0, o.err, o.cause}, {27'd0, 1'b1, 4'd7});
    check("to_sb_strobes", 32'(o.rd_cnt * 16 + o.we_cnt), 32'h40);
    do_req(1'b1, 2'd2, 1'b0, 32'h104, 32'h0, "to_sw", o);
    check("to_sw_err", {27'd0, o.err, o.cause}, {27'd0, 1'b1, 4'd7});
    check("to_sw_we_cnt", 32'(o.we_cnt), 4);
`endif

    // Reset during the ready-low wait of a store
    ready_mode = 2;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h104; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_we_before", 32'(we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {30'd0, we, rd}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("mid_rst_no_rsp", 32'(seen), 0);
    check("mid_rst_req_ready", 32'(req_ready), 1);

    // Random traffic against the byte-array model
    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      logic rwe, uns;
      logic [1:0] sz;
      logic [31:0] addr, wdata;
      rwe = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
      addr = $urandom_range(0, 1023); wdata = $urandom;
      model(rwe, sz, uns, addr, wdata, erd, ee, ec);
      do_req(rwe, sz, uns, addr, wdata, $sformatf("r%0d", n), o);
      check($sformatf("r%0d_err", n), {27'd0, o.err, o.cause}, {27'd0, ee, ec});
      if (!rwe && !ee) check($sformatf("r%0d_rdata", n), o.rdata, erd);
    end

    nbad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check("mem_final_bad_bytes", 32'(nbad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
